// File: rtl/crc_pkg.sv
// CRC-32 stream engine shared types and constants.
// Byte step is reflected (LSB-first) to match Ethernet FCS order.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    APPEND
  } crc_state_e;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_XOROUT  = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  function automatic logic [31:0] crc_byte(
    input logic [31:0] crc,
    input logic [7:0]  data,
    input logic [31:0] poly
  );
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ poly) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_stream_engine_if.sv
// Valid/ready beat stream with byte keep and frame markers.
// Master drives the beat, slave returns ready.
interface crc_stream_engine_if #(
  parameter int DATA_BYTES = 4
);

  logic [8*DATA_BYTES-1:0] data;
  logic [DATA_BYTES-1:0]   keep;
  logic                    sof;
  logic                    eof;
  logic                    valid;
  logic                    ready;

  modport master (
    output data, keep, sof, eof, valid,
    input  ready
  );

  modport slave (
    input  data, keep, sof, eof, valid,
    output ready
  );

endinterface

// File: rtl/crc_lane_chain.sv
// Combinational CRC cascade across the lanes of one beat.
// Lane 0 is processed first; lanes with keep low pass through.
module crc_lane_chain
  import crc_pkg::*;
#(
  parameter int          DATA_BYTES = 4,
  parameter logic [31:0] POLY       = CRC_POLY
) (
  input  logic [31:0]             crc_in,
  input  logic [8*DATA_BYTES-1:0] data,
  input  logic [DATA_BYTES-1:0]   keep,
  output logic [31:0]             crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (keep[i]) begin
        crc_out = crc_byte(crc_out, data[8*i +: 8], POLY);
      end
    end
  end

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC-32 engine: appends FCS in generate mode,
// verifies residue in check mode. One output register stage.
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int          DATA_BYTES = 4,
  parameter logic [31:0] POLY       = CRC_POLY,
  parameter logic [31:0] INIT       = CRC_INIT,
  parameter logic [31:0] XOROUT     = CRC_XOROUT,
  parameter logic [31:0] RESIDUE    = CRC_RESIDUE
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                Mode,
  crc_stream_engine_if.slave  s,
  crc_stream_engine_if.master m,
  output logic [31:0]         CRC_out,
  output logic                CRC_valid,
  output logic                CRC_ok
);

  localparam int W         = 8 * DATA_BYTES;
  localparam int FCS_BEATS = (4 + DATA_BYTES - 1) / DATA_BYTES;
  localparam logic [2:0] FCS_LAST = 3'(FCS_BEATS - 1);

  crc_state_e state_q;
  crc_state_e state_d;

  logic                  mode_q;
  logic [31:0]           crc_q;
  logic [31:0]           crc_seed;
  logic [31:0]           crc_next;
  logic [31:0]           fcs_word;
  logic [31:0]           fcs_sh;
  logic [2:0]            fcs_idx;
  logic [W-1:0]          fcs_data;
  logic [DATA_BYTES-1:0] fcs_keep;

  logic [W-1:0]          data_q;
  logic [DATA_BYTES-1:0] keep_q;
  logic                  sof_q;
  logic                  eof_q;
  logic                  valid_q;
  logic                  pulse_q;
  logic                  ok_q;

  logic out_free;
  logic acc;
  logic take;
  logic drop;
  logic mode_eff;
  logic load_fcs;
  logic fcs_done;

  assign out_free = !valid_q || m.ready;
  assign s.ready  = (state_q != APPEND) && out_free;
  assign acc      = s.valid && s.ready;
  assign drop     = (state_q == IDLE) && !s.sof;
  assign take     = acc && !drop;
  assign mode_eff = s.sof ? Mode : mode_q;
  assign load_fcs = (state_q == APPEND) && out_free;
  assign fcs_done = (fcs_idx == FCS_LAST);
  assign crc_seed = s.sof ? INIT : crc_q;
  assign fcs_word = crc_q ^ XOROUT;

  assign m.data    = data_q;
  assign m.keep    = keep_q;
  assign m.sof     = sof_q;
  assign m.eof     = eof_q;
  assign m.valid   = valid_q;
  assign CRC_out   = fcs_word;
  assign CRC_valid = pulse_q;
  assign CRC_ok    = ok_q;

  crc_lane_chain #(
    .DATA_BYTES(DATA_BYTES),
    .POLY      (POLY)
  ) u_chain (
    .crc_in (crc_seed),
    .data   (s.data),
    .keep   (s.keep),
    .crc_out(crc_next)
  );

  // FCS byte n lands on lane n mod DATA_BYTES of beat n / DATA_BYTES
  always_comb begin
    fcs_data = '0;
    fcs_keep = '0;
    fcs_sh   = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      fcs_sh = fcs_word >> (8 * (int'(fcs_idx) * DATA_BYTES + i));
      if (int'(fcs_idx) * DATA_BYTES + i < 4) begin
        fcs_data[8*i +: 8] = fcs_sh[7:0];
        fcs_keep[i]        = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q == APPEND: begin
        if (load_fcs && fcs_done) state_d = IDLE;
      end
      take: begin
        if (!s.eof)       state_d = DATA;
        else if (mode_eff) state_d = IDLE;
        else              state_d = APPEND;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      mode_q  <= 1'b0;
      crc_q   <= INIT;
      fcs_idx <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      valid_q <= 1'b0;
      pulse_q <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (take) begin
        crc_q   <= crc_next;
        fcs_idx <= '0;
        if (s.sof) mode_q <= Mode;
        if (s.eof) begin
          pulse_q <= 1'b1;
          ok_q    <= mode_eff && (crc_next == RESIDUE);
        end
      end
      if (load_fcs) fcs_idx <= fcs_idx + 3'd1;
      // gen mode moves eof from the last data beat to the last FCS beat
      if (out_free) begin
        if (take) begin
          valid_q <= 1'b1;
          data_q  <= s.data;
          keep_q  <= s.keep;
          sof_q   <= s.sof;
          eof_q   <= s.eof && mode_eff;
        end else if (load_fcs) begin
          valid_q <= 1'b1;
          data_q  <= fcs_data;
          keep_q  <= fcs_keep;
          sof_q   <= 1'b0;
          eof_q   <= fcs_done;
        end else begin
          valid_q <= 1'b0;
        end
      end
    end
  end

endmodule
